// File: rtl/sram_reader.sv
// Read port for the external 256K x 16 async SRAM: request/valid interface with
// timed read cycles, a one-word sequential prefetch buffer and writer arbitration.
module sram_reader #(
  parameter int WAIT_CYCLES = 2,
  parameter int PREFETCH    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [17:0] addr,
  output logic        ready,
  output logic [15:0] rdata,
  output logic        rvalid,
  input  logic        wr_busy,
  output logic        rd_busy,
  output logic [17:0] sram_addr,
  output logic        sram_cen,
  output logic        sram_oen,
  input  logic [15:0] sram_din
);

  typedef enum logic [1:0] {IDLE, RD, PF} state_t;

  localparam logic [3:0] WAIT_CNT = 4'(WAIT_CYCLES);
  localparam bit         PF_EN    = (PREFETCH != 0);

  state_t      state;
  logic [3:0]  cnt;
  logic [17:0] buf_addr;
  logic [15:0] buf_data;
  logic        buf_valid;
  logic        pf_clean;
  logic        accept;
  logic        hit;

  assign ready   = (state == IDLE) && !wr_busy;
  assign accept  = req && ready;
  assign rd_busy = (state != IDLE) || accept;
  assign hit     = PF_EN && buf_valid && (addr == buf_addr);

  // pf_clean remembers whether the writer stayed away for the whole prefetch,
  // so a buffered word is only trusted if nobody could have overwritten it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      sram_addr <= 18'd0;
      sram_cen  <= 1'b1;
      sram_oen  <= 1'b1;
      rdata     <= 16'd0;
      rvalid    <= 1'b0;
      buf_addr  <= 18'd0;
      buf_data  <= 16'd0;
      buf_valid <= 1'b0;
      pf_clean  <= 1'b0;
    end else begin
      rvalid <= 1'b0;
      if (wr_busy) buf_valid <= 1'b0;
      case (state)
        IDLE: begin
          sram_cen <= 1'b1;
          sram_oen <= 1'b1;
          if (accept) begin
            cnt      <= WAIT_CNT;
            sram_cen <= 1'b0;
            sram_oen <= 1'b0;
            pf_clean <= 1'b1;
            if (hit) begin
              rdata     <= buf_data;
              rvalid    <= 1'b1;
              sram_addr <= addr + 18'd1;
              state     <= PF;
            end else begin
              sram_addr <= addr;
              state     <= RD;
            end
          end
        end
        RD: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            rdata  <= sram_din;
            rvalid <= 1'b1;
            // chip enable stays low straight into the prefetch
            if (PF_EN && !wr_busy) begin
              state     <= PF;
              sram_addr <= sram_addr + 18'd1;
              cnt       <= WAIT_CNT;
              pf_clean  <= 1'b1;
            end else begin
              state    <= IDLE;
              sram_cen <= 1'b1;
              sram_oen <= 1'b1;
            end
          end
        end
        PF: begin
          if (wr_busy) pf_clean <= 1'b0;
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            buf_data  <= sram_din;
            buf_addr  <= sram_addr;
            buf_valid <= pf_clean && !wr_busy;
            state     <= IDLE;
            sram_cen  <= 1'b1;
            sram_oen  <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          sram_cen <= 1'b1;
          sram_oen <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_reader.sv
// Self-checking bench for sram_reader: directed corner sequences, a constant
// vector table, and random traffic checked against a transaction-level model.
module tb_sram_reader;

  localparam int W = 2;

  logic        clk;
  logic        rst;
  logic        req;
  logic [17:0] addr;
  logic        ready;
  logic [15:0] rdata;
  logic        rvalid;
  logic        wr_busy;
  logic        rd_busy;
  logic [17:0] sram_addr;
  logic        sram_cen;
  logic        sram_oen;
  logic [15:0] sram_din;

  logic [15:0] mem [0:262143];

  int checks;
  int failures;

  // transaction-level view of the prefetch buffer
  bit          buf_ok;
  logic [17:0] buf_next;

  typedef struct {
    logic [17:0] a;
    bit          hit;
    logic [15:0] data;
  } vec_t;

  vec_t vecs [8];

  sram_reader #(.WAIT_CYCLES(W), .PREFETCH(1)) dut (
    .clk(clk), .rst(rst), .req(req), .addr(addr), .ready(ready),
    .rdata(rdata), .rvalid(rvalid), .wr_busy(wr_busy), .rd_busy(rd_busy),
    .sram_addr(sram_addr), .sram_cen(sram_cen), .sram_oen(sram_oen),
    .sram_din(sram_din)
  );

  assign sram_din = (!sram_cen && !sram_oen) ? mem[sram_addr] : 16'hDEAD;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string what, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", what, act, exp);
    end
  endtask

  // One read transaction from request to the reader going idle again.
  task automatic applyStimulus(input logic [17:0] a, input bit exp_hit,
                               input logic [15:0] exp_data, input string name);
    int waited, lat, pulses, dem, pfc, low;
    bit done;
    logic [15:0] got;
    logic [17:0] nxt;
    nxt = a + 18'd1;
    req = 1'b1;
    addr = a;
    #1;
    waited = 0;
    while (!ready && waited < 100) begin
      @(negedge clk); #1;
      waited++;
    end
    if (!ready) begin
      checkOutput({name, ".acceptTimeout"}, 32'd0, 32'd1);
      req = 1'b0;
      return;
    end
    checkOutput({name, ".rdBusyAccept"}, 32'(rd_busy), 32'd1);
    lat = 0; pulses = 0; dem = 0; pfc = 0; low = 0; got = 16'h0; done = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk); #1;
      if (k == 1) req = 1'b0;
      if (rvalid) begin
        pulses++;
        if (lat == 0) begin
          lat = k;
          got = rdata;
        end
      end
      if (!sram_cen) begin
        low++;
        if (sram_addr == a) dem++;
        else if (sram_addr == nxt) pfc++;
      end
      if (ready && sram_cen) begin
        done = 1'b1;
        break;
      end
    end
    checkOutput({name, ".finished"}, 32'(done), 32'd1);
    checkOutput({name, ".latency"}, 32'(lat), exp_hit ? 32'd1 : 32'(W + 2));
    checkOutput({name, ".data"}, 32'(got), 32'(exp_data));
    checkOutput({name, ".pulses"}, 32'(pulses), 32'd1);
    checkOutput({name, ".demandCycles"}, 32'(dem), exp_hit ? 32'd0 : 32'(W + 1));
    checkOutput({name, ".prefetchCycles"}, 32'(pfc), 32'(W + 1));
    checkOutput({name, ".cenLowCycles"}, 32'(low), exp_hit ? 32'(W + 1) : 32'(2 * W + 2));
    checkOutput({name, ".rdataHold"}, 32'(rdata), 32'(exp_data));
    buf_ok = 1'b1;
    buf_next = nxt;
  endtask

  task automatic writerBurst(input int n, input logic [17:0] wa, input logic [15:0] wv);
    wr_busy = 1'b1;
    for (int i = 0; i < n; i++) begin
      #1;
      checkOutput("writer.ready", 32'(ready), 32'd0);
      checkOutput("writer.rdBusy", 32'(rd_busy), 32'd0);
      if (i == 0) mem[wa] = wv;
      @(negedge clk);
    end
    wr_busy = 1'b0;
    buf_ok = 1'b0;
    #1;
  endtask

  initial begin
    int pulses;
    logic [17:0] a, last_a, wa;
    bit exp_hit;

    checks = 0;
    failures = 0;
    buf_ok = 1'b0;
    buf_next = 18'd0;
    rst = 1'b1;
    req = 1'b0;
    addr = 18'd0;
    wr_busy = 1'b0;
    for (int i = 0; i < 262144; i++) mem[i] = 16'(i) ^ 16'h5A5A;
    mem[18'h00010] = 16'hBEEF;
    mem[18'h00011] = 16'h1234;
    mem[18'h00012] = 16'hC012;
    mem[18'h00013] = 16'hC013;
    mem[18'h00014] = 16'hC014;
    mem[18'h3FFFF] = 16'hF0FF;
    mem[18'h00000] = 16'h0A0A;
    mem[18'h00100] = 16'hA100;
    mem[18'h00101] = 16'hA101;
    mem[18'h00102] = 16'hA102;
    mem[18'h00200] = 16'hB200;
    mem[18'h00201] = 16'hB201;

    vecs[0] = '{18'h00100, 1'b0, 16'hA100};
    vecs[1] = '{18'h00101, 1'b1, 16'hA101};
    vecs[2] = '{18'h00102, 1'b1, 16'hA102};
    vecs[3] = '{18'h00200, 1'b0, 16'hB200};
    vecs[4] = '{18'h00201, 1'b1, 16'hB201};
    vecs[5] = '{18'h00100, 1'b0, 16'hA100};
    vecs[6] = '{18'h00100, 1'b0, 16'hA100};
    vecs[7] = '{18'h00101, 1'b1, 16'hA101};

    // reset state
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("reset.cen", 32'(sram_cen), 32'd1);
    checkOutput("reset.oen", 32'(sram_oen), 32'd1);
    checkOutput("reset.rvalid", 32'(rvalid), 32'd0);
    checkOutput("reset.ready", 32'(ready), 32'd1);
    checkOutput("reset.rdBusy", 32'(rd_busy), 32'd0);
    checkOutput("reset.rdata", 32'(rdata), 32'h0);
    checkOutput("reset.sramAddr", 32'(sram_addr), 32'h0);

    applyStimulus(18'h00010, 1'b0, 16'hBEEF, "miss");
    applyStimulus(18'h00011, 1'b1, 16'h1234, "seqHit");
    applyStimulus(18'h3FFFF, 1'b0, 16'hF0FF, "wrapMiss");
    applyStimulus(18'h00000, 1'b1, 16'h0A0A, "wrapHit");

    // writer grabs the SRAM right after a prefetch of 0x13 and rewrites it
    applyStimulus(18'h00012, 1'b0, 16'hC012, "preInterlock");
    wr_busy = 1'b1;
    req = 1'b1;
    addr = 18'h00013;
    for (int i = 0; i < 5; i++) begin
      #1;
      checkOutput("interlock.ready", 32'(ready), 32'd0);
      checkOutput("interlock.rdBusy", 32'(rd_busy), 32'd0);
      if (i == 2) mem[18'h00013] = 16'h5A5A;
      @(negedge clk);
    end
    wr_busy = 1'b0;
    buf_ok = 1'b0;
    applyStimulus(18'h00013, 1'b0, 16'h5A5A, "interlock");

    // reset lands in the second RD cycle of a miss
    req = 1'b1;
    addr = 18'h00040;
    #1;
    checkOutput("midReset.ready", 32'(ready), 32'd1);
    @(negedge clk); #1;
    req = 1'b0;
    checkOutput("midReset.cenLow", 32'(sram_cen), 32'd0);
    @(negedge clk); #1;
    rst = 1'b1;
    @(negedge clk); #1;
    rst = 1'b0;
    buf_ok = 1'b0;
    checkOutput("midReset.cen", 32'(sram_cen), 32'd1);
    checkOutput("midReset.oen", 32'(sram_oen), 32'd1);
    checkOutput("midReset.ready", 32'(ready), 32'd1);
    pulses = 0;
    if (rvalid) pulses++;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      if (rvalid) pulses++;
    end
    checkOutput("midReset.noRvalid", 32'(pulses), 32'd0);
    applyStimulus(18'h00014, 1'b0, 16'hC014, "postReset14");
    applyStimulus(18'h00012, 1'b0, 16'hC012, "postReset12");

    for (int v = 0; v < 8; v++)
      applyStimulus(vecs[v].a, vecs[v].hit, vecs[v].data, $sformatf("vec%0d", v));

    // random traffic: sequential runs, jumps and writer bursts
    last_a = 18'h00101;
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 9) < 2) begin
        wa = (buf_ok && $urandom_range(0, 1) == 1) ? buf_next : 18'($urandom);
        writerBurst(int'($urandom_range(1, 4)), wa, 16'($urandom));
      end
      if ($urandom_range(0, 1) == 1) a = last_a + 18'd1;
      else a = 18'($urandom);
      exp_hit = buf_ok && (a == buf_next);
      applyStimulus(a, exp_hit, mem[a], $sformatf("rand%0d", t));
      last_a = a;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
